cache_arbiter: RTL and testbench

Shares the single physical-memory / L2 port between the instruction-cache miss path and the data-cache miss path feeding the pipelined datapath.
- Two requesters: I-side (read-only) and D-side (read/write).
- Latches one whole-line transaction, drives it downstream until pmem_resp, then returns data and a one-cycle resp to the granted requester.
- Sits between the split I/D caches and the memory model or L2.

---
 rtl/arb_types.sv | 24 ++
 rtl/arb_grant_sel.sv | 28 ++
 rtl/cache_arbiter.sv | 112 +++++++++++
 tb/tb_cache_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_types.sv
// Shared types and constants for the I/D cache miss-path arbiter.
// The default build has no optional features; see cache_arbiter.sv for CACHE_ARB_ROUND_ROBIN_EN.
package arb_types;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } arb_req_t;

   localparam int LINE_WIDTH_DEFAULT = 256;
   localparam int LINE_OFFSET_BITS   = $clog2(LINE_WIDTH_DEFAULT / 8);

   // Number of byte-offset bits inside one cache line of the given width.
   function automatic int line_offset_bits(input int line_width);
      return $clog2(line_width / 8);
   endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner select between the I-side and D-side miss requests.
// CACHE_ARB_ROUND_ROBIN_EN selects alternating priority on contention; otherwise D-side wins.
module arb_grant_sel
   import arb_types::*;
(
   input  logic     i_req,
   input  logic     d_req,
   input  arb_req_t last_grant,
   output arb_req_t grant
);

   always_comb begin
      // With no request the result is unused; holding last_grant keeps it stable.
      grant = last_grant;
      if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
         grant = REQ_D;
`endif
      end else if (d_req) begin
         grant = REQ_D;
      end else if (i_req) begin
         grant = REQ_I;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-wide pmem/L2 port between the I-cache and D-cache miss paths.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN: alternate the winner on contested IDLE cycles.
module cache_arbiter
   import arb_types::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,

   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   localparam int OFFSET_BITS = line_offset_bits(LINE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

   arb_state_t state;
   arb_req_t   grant;
   arb_req_t   last_grant;
   logic       d_req;
   logic       any_req;

   assign d_req   = d_read | d_write;
   assign any_req = i_read | d_req;

   arb_grant_sel u_grant_sel (
      .i_req      (i_read),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= REQ_I;
      end else if (state == IDLE && any_req) begin
         last_grant <= grant;
      end
   end
`else
   assign last_grant = REQ_I;
`endif

   // Downstream request fields are registered so requester inputs never reach pmem directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  if (grant == REQ_D) begin
                     state        <= BUSY_D;
                     pmem_write   <= d_write;
                     pmem_read    <= ~d_write;
                     pmem_address <= d_address & ADDR_MASK;
                     pmem_wdata   <= d_wdata;
                  end else begin
                     state        <= BUSY_I;
                     pmem_write   <= 1'b0;
                     pmem_read    <= 1'b1;
                     pmem_address <= i_address & ADDR_MASK;
                     pmem_wdata   <= '0;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               // Completion does not depend on the requester still holding its request.
               if (pmem_resp) begin
                  state      <= IDLE;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

   assign i_resp  = (state == BUSY_I) && pmem_resp;
   assign d_resp  = (state == BUSY_D) && pmem_resp;
   assign i_rdata = i_resp ? pmem_rdata : '0;
   assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level priority/alignment model.
module tb_cache_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   int checks = 0;
   int errors = 0;
   bit last_d = 1'b0;

   cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "simulation time limit reached");
   end

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // A 32-byte line: the low five address bits select a byte within it.
   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return (a / 32) * 32;
   endfunction

   function automatic bit pick_d(input bit i_p, input bit d_p);
      if (i_p && d_p) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         return !last_d;
`else
         return 1'b1;
`endif
      end
      return d_p;
   endfunction

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pmem_read"},    pmem_read,    0);
      check({tag, "_pmem_write"},   pmem_write,   0);
      check({tag, "_pmem_address"}, pmem_address, 0);
      check({tag, "_pmem_wdata"},   pmem_wdata,   0);
      check({tag, "_resps"},        {i_resp, d_resp}, 0);
      check({tag, "_i_rdata"},      i_rdata,      0);
      check({tag, "_d_rdata"},      d_rdata,      0);
   endtask

   // Called from an IDLE-cycle negedge in which the request was visible.
   task automatic expect_issue(input bit exp_d, input bit exp_wr,
                               input logic [AW-1:0] addr, input logic [LW-1:0] wd);
      @(negedge clk);
      check("issue_read",  pmem_read,  !exp_wr);
      check("issue_write", pmem_write, exp_wr);
      check("issue_addr",  pmem_address, align(addr));
      if (exp_wr) check("issue_wdata", pmem_wdata, wd);
      last_d = exp_d;
   endtask

   task automatic hold(input int lat, input logic [AW-1:0] addr);
      repeat (lat) begin
         @(negedge clk);
         check("hold_addr",   pmem_address, align(addr));
         check("hold_op",     pmem_read | pmem_write, 1);
         check("hold_noresp", {i_resp, d_resp}, 0);
      end
   endtask

   task automatic complete(input bit exp_d, input logic [LW-1:0] rd);
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      check("i_resp",  i_resp,  !exp_d);
      check("d_resp",  d_resp,  exp_d);
      check("i_rdata", i_rdata, exp_d ? '0 : rd);
      check("d_rdata", d_rdata, exp_d ? rd : '0);
      @(posedge clk);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (exp_d) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
      @(negedge clk);
      check("idle_op",     pmem_read | pmem_write, 0);
      check("idle_resps",  {i_resp, d_resp}, 0);
      check("idle_rdata",  i_rdata | d_rdata, 0);
   endtask

   task automatic serve(input bit exp_d, input bit exp_wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wd, input int lat);
      expect_issue(exp_d, exp_wr, addr, wd);
      hold(lat, addr);
      complete(exp_d, rand_line());
   endtask

   initial begin
      bit            i_p;
      bit            d_p;
      bit            w;
      bit            wr;
      logic [AW-1:0] a;

      rst        = 1'b1;
      i_read     = 1'b0;
      i_address  = '0;
      d_read     = 1'b0;
      d_write    = 1'b0;
      d_address  = '0;
      d_wdata    = '0;
      pmem_rdata = rand_line();
      pmem_resp  = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      last_d = 1'b0;
      @(negedge clk);

      // Single I-side read, resp on the third busy cycle, fixed line pattern.
      i_read = 1'b1;
      i_address = 32'h0000_0064;
      expect_issue(1'b0, 1'b0, 32'h0000_0064, '0);
      check("t1_addr_literal", pmem_address, 32'h0000_0060);
      hold(2, 32'h0000_0064);
      complete(1'b0, {32{8'hA5}});

      // Simultaneous requests: D-side first, then the waiting I-side.
      i_read = 1'b1;
      i_address = 32'h100;
      d_read = 1'b1;
      d_address = 32'h200;
      serve(1'b1, 1'b0, 32'h200, '0, 1);
      serve(1'b0, 1'b0, 32'h100, '0, 0);

      // Write-back with unaligned address.
      d_write = 1'b1;
      d_address = 32'h1000_003F;
      d_wdata = {4{64'h0123_4567_89AB_CDEF}};
      expect_issue(1'b1, 1'b1, 32'h1000_003F, {4{64'h0123_4567_89AB_CDEF}});
      check("t3_addr_literal", pmem_address, 32'h1000_0020);
      hold(1, 32'h1000_003F);
      complete(1'b1, rand_line());

      // Asynchronous reset in the middle of a D-side read.
      d_read = 1'b1;
      d_address = 32'h200;
      expect_issue(1'b1, 1'b0, 32'h200, '0);
      hold(1, 32'h200);
      @(negedge clk);
      rst = 1'b1;
      pmem_resp = 1'b1;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      d_read = 1'b0;
      pmem_resp = 1'b0;
      rst = 1'b0;
      last_d = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b1;
      #1;
      check("idle_resp_ignored", {i_resp, d_resp}, 0);
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      @(negedge clk);
      check("idle_resp_no_op", pmem_read | pmem_write, 0);

      // D request arriving during BUSY_I waits for the next grant.
      i_read = 1'b1;
      i_address = 32'h300;
      expect_issue(1'b0, 1'b0, 32'h300, '0);
      d_read = 1'b1;
      d_address = 32'h45C;
      hold(3, 32'h300);
      complete(1'b0, rand_line());
      serve(1'b1, 1'b0, 32'h45C, '0, 2);

      // Requester drops early; the transaction and its resp still complete.
      i_read = 1'b1;
      i_address = 32'h500;
      expect_issue(1'b0, 1'b0, 32'h500, '0);
      i_read = 1'b0;
      hold(1, 32'h500);
      complete(1'b0, rand_line());

      // Continuous contention for four transactions from a fresh reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_d = 1'b0;
      @(negedge clk);
      i_read = 1'b1;
      i_address = 32'h600;
      d_read = 1'b1;
      d_address = 32'h700;
      for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         w = (k % 2 == 0);
`else
         w = 1'b1;
`endif
         serve(w, 1'b0, w ? 32'h700 : 32'h600, '0, 1);
         if (w) d_read = 1'b1;
         else   i_read = 1'b1;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      @(negedge clk);
      check("contention_drained", pmem_read | pmem_write, 0);

      // Randomized traffic against the priority/alignment model.
      i_p = 1'b0;
      d_p = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!i_p && $urandom_range(0, 1) == 1) begin
            i_p = 1'b1;
            i_read = 1'b1;
            i_address = $urandom;
         end
         if (!d_p && ($urandom_range(0, 1) == 1 || !i_p)) begin
            int op;
            op = $urandom_range(0, 2);
            d_p = 1'b1;
            d_read  = (op != 1);
            d_write = (op != 0);
            d_address = $urandom;
            d_wdata = rand_line();
         end
         w  = pick_d(i_p, d_p);
         wr = w && d_write;
         a  = w ? d_address : i_address;
         serve(w, wr, a, d_wdata, $urandom_range(0, 4));
         if (w) d_p = 1'b0;
         else   i_p = 1'b0;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      d_write = 1'b0;
      @(negedge clk);
      check("final_idle", pmem_read | pmem_write, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
